joypad_responder: RTL and testbench

//  Console-facing end of the NES controller serial link: emulates the controller's 4021 shift register.

---
 rtl/joypad_responder_if.sv | 8 +
 rtl/joypad_responder.sv | 82 ++++++++
 tb/tb_joypad_responder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/joypad_responder_if.sv
// joypad_responder_if: console-side serial link of an NES controller port
interface joypad_responder_if;
  logic joy_strobe;
  logic joy_clock;
  logic joy_data;
  modport master(output joy_strobe, output joy_clock, input joy_data);
  modport slave(input joy_strobe, input joy_clock, output joy_data);
endinterface

// File: rtl/joypad_responder.sv
// joypad_responder: emulates a 4021-based NES pad with debounced buttons and A/B turbo
module joypad_responder #(
  parameter int          SYNC_STAGES     = 2,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd8000,
  parameter logic [19:0] TURBO_DIV       = 20'd200000
) (
  input  logic                clock,
  input  logic                reset,
  joypad_responder_if.slave   bus,
  input  logic [7:0]          buttons_n,
  input  logic [1:0]          turbo_en,
  output logic [7:0]          buttons_db,
  output logic [3:0]          bit_count
);
  logic [SYNC_STAGES-1:0] strobe_sync, clk_sync;
  logic                   s_strobe, s_clk, s_clk_d, clk_rise, phase;
  logic [19:0]            tcnt;
  logic [15:0]            cnt [8];
  logic [7:0]             raw, eff, sr, sr_next;
  logic [3:0]             count_next;

  assign s_strobe = strobe_sync[SYNC_STAGES-1];
  assign s_clk    = clk_sync[SYNC_STAGES-1];
  assign clk_rise = s_clk & ~s_clk_d;
  assign raw      = ~buttons_n;
  assign eff      = buttons_db & {6'h3f, turbo_en[1] ? phase : 1'b1, turbo_en[0] ? phase : 1'b1};

  // Strobe has priority; vacated bits fill with 1 so an over-read reports "pressed" like a real pad
  always_comb begin
    sr_next    = s_strobe ? eff : clk_rise ? {1'b1, sr[7:1]} : sr;
    count_next = s_strobe ? 4'd0 : (clk_rise && bit_count != 4'd8) ? bit_count + 4'd1 : bit_count;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      strobe_sync <= '0;
      clk_sync    <= '0;
      s_clk_d     <= 1'b0;
      sr          <= 8'h00;
      bit_count   <= 4'd0;
      bus.joy_data <= 1'b1;
    end else begin
      strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], bus.joy_strobe};
      clk_sync    <= {clk_sync[SYNC_STAGES-2:0], bus.joy_clock};
      s_clk_d     <= s_clk;
      sr          <= sr_next;
      bit_count   <= count_next;
      bus.joy_data <= ~sr_next[0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tcnt  <= '0;
      phase <= 1'b0;
    end else begin
      tcnt  <= (tcnt == TURBO_DIV - 20'd1) ? 20'd0 : tcnt + 20'd1;
      phase <= (tcnt == TURBO_DIV - 20'd1) ? ~phase : phase;
    end
  end

  // A button change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clock) begin
    if (reset) begin
      buttons_db <= 8'h00;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (raw[i] != buttons_db[i]) begin
          if (cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
            buttons_db[i] <= raw[i];
            cnt[i]        <= '0;
          end else begin
            cnt[i] <= cnt[i] + 16'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_joypad_responder.sv
// tb_joypad_responder: randomized console/pad traffic checked through a scoreboard queue
module tb_joypad_responder;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int TDIV = 8;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      name;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  buttons_n = 8'hFF;
  logic [1:0]  turbo_en = 2'b00;
  logic [7:0]  buttons_db;
  logic [3:0]  bit_count;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        q[$];
  event        sample_ev;

  joypad_responder_if bus();

  joypad_responder #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(16'(DEB)), .TURBO_DIV(20'(TDIV))) dut (
    .clock(clock), .reset(reset), .bus(bus), .buttons_n(buttons_n),
    .turbo_en(turbo_en), .buttons_db(buttons_db), .bit_count(bit_count)
  );

  always #5 clock = ~clock;

  // Non-reset clock edges since the last reset: the turbo phase is (cyc / TDIV) mod 2
  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  always begin
    @(sample_ev);
    while (q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e = q.pop_front();
      act = e.kind == 0 ? {7'b0, bus.joy_data} : e.kind == 1 ? {4'b0, bit_count} : buttons_db;
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input int kind, input logic [7:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
    ->sample_ev;
    #0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    chk(0, 8'h01, "rst_joy_data");
    chk(1, 8'h00, "rst_bit_count");
    chk(2, 8'h00, "rst_buttons_db");
    reset = 1'b0;
  endtask

  // One console read: load, then 10 clock pulses; stops after max_shift pulses if asked
  task automatic frame(input logic [7:0] pressed, input logic [1:0] ten, input bit glitch,
                       input int max_shift);
    int l;
    logic ph;
    logic [7:0] eff;
    l = $urandom_range(3, 6);
    bus.joy_strobe = 1'b1;
    repeat (l) begin
      bus.joy_clock = 1'($urandom_range(0, 1));
      tick();
    end
    bus.joy_strobe = 1'b0;
    bus.joy_clock  = 1'b0;
    ph  = 1'(((cyc + SYNC - 1) / TDIV) % 2);
    eff = pressed;
    if (ten[0]) eff[0] = eff[0] & ph;
    if (ten[1]) eff[1] = eff[1] & ph;
    tick(4);
    chk(0, {7'b0, ~eff[0]}, "load_bit0");
    chk(1, 8'h00, "load_count");
    for (int j = 1; j <= max_shift; j++) begin
      bus.joy_clock = 1'b1;
      tick(4);
      bus.joy_clock = 1'b0;
      tick(4);
      if (j == 4) buttons_n = 8'($urandom);
      if (glitch && j == 3) begin
        #2 bus.joy_strobe = 1'b1;
        #4 bus.joy_strobe = 1'b0;
        tick();
      end
      chk(0, j < 8 ? {7'b0, ~eff[j]} : 8'h00, "shift_bit");
      chk(1, 8'(j < 8 ? j : 8), "shift_count");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] p;
    bus.joy_strobe = 1'b0;
    bus.joy_clock  = 1'b0;
    tick();
    do_reset();
    tick();
    buttons_n = 8'hFE;
    tick(3);
    chk(2, 8'h00, "deb_early");
    tick();
    chk(2, 8'h01, "deb_accept");
    buttons_n = 8'hFF;
    tick(3);
    buttons_n = 8'hFE;
    tick();
    buttons_n = 8'hFF;
    tick(3);
    chk(2, 8'h01, "deb_glitch");
    tick();
    chk(2, 8'h00, "deb_release");
    buttons_n = 8'hF6;
    tick(DEB + 2);
    chk(2, 8'h09, "db_a_start");
    frame(8'h09, 2'b00, 1'b0, 10);
    turbo_en = 2'b01;
    buttons_n = 8'hFC;
    tick(DEB + 2);
    for (int k = 0; k < 6; k++) begin
      buttons_n = 8'hFC;
      tick($urandom_range(0, 7));
      frame(8'h03, 2'b01, 1'b0, 1);
    end
    buttons_n = 8'($urandom) | 8'h01;
    p = ~buttons_n;
    turbo_en = 2'b00;
    tick(DEB + 2);
    frame(p, 2'b00, 1'b0, 3);
    do_reset();
    for (int k = 0; k < 40; k++) begin
      buttons_n = 8'($urandom);
      turbo_en  = 2'($urandom);
      p = ~buttons_n;
      tick(DEB + 2);
      chk(2, p, "rand_db");
      frame(p, turbo_en, 1'($urandom_range(0, 1)), 10);
    end
    tick(2);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
